// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - truth-table sweep driver and capture checker for a 3-input gate netlist
//
// Walks the eight input rows of a combinational circuit, holds each row for
// SETTLE cycles, checks that the circuit output is steady over the last STABLE
// cycles of each row, and assembles the measured truth table (row 0 in the MSB).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a sweep (taken only when idle)
//   drv_in2/drv_in1/drv_in3   drives to the circuit inputs, {in2,in1,in3} = row
//   dut_out                   circuit output
//   busy                      sweep in progress
//   done                      one-cycle pulse when the result becomes valid
//   result_valid              tt / unstable_mask / pass hold a completed sweep
//   tt                        measured truth table, row r in bit 7-r
//   unstable_mask             per-row instability flags, same bit order as tt
//   mismatch_mask             tt ^ EXPECTED
//   pass                      tt matches EXPECTED and no row was unstable
module tt_sweep_capture #(
    parameter int         SETTLE   = 4,
    parameter int         STABLE   = 2,
    parameter logic [7:0] EXPECTED = 8'hBC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_in2,
    output logic       drv_in1,
    output logic       drv_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [7:0] tt,
    output logic [7:0] unstable_mask,
    output logic [7:0] mismatch_mask,
    output logic       pass
);

    localparam logic [7:0] WIN_START = 8'(SETTLE - STABLE);
    localparam logic [7:0] LAST_CNT  = 8'(SETTLE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t     state, state_n;
    logic [2:0] row, row_n;
    logic [7:0] cnt, cnt_n;
    logic       ref_bit, ref_bit_n;
    logic [7:0] tt_q, tt_n;
    logic [7:0] unst_q, unst_n;
    logic       pass_q, pass_n;
    logic       valid_q, valid_n;
    logic       done_q, done_n;

    // Row r is stored at bit 7-r; for a 3-bit index that is just ~r.
    logic [2:0] bit_idx;
    assign bit_idx = ~row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= 3'd0;
            cnt     <= 8'd0;
            ref_bit <= 1'b0;
            tt_q    <= 8'h00;
            unst_q  <= 8'h00;
            pass_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            cnt     <= cnt_n;
            ref_bit <= ref_bit_n;
            tt_q    <= tt_n;
            unst_q  <= unst_n;
            pass_q  <= pass_n;
            valid_q <= valid_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        cnt_n     = cnt;
        ref_bit_n = ref_bit;
        tt_n      = tt_q;
        unst_n    = unst_q;
        pass_n    = pass_q;
        valid_n   = valid_q;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    row_n   = 3'd0;
                    cnt_n   = 8'd0;
                    tt_n    = 8'h00;
                    unst_n  = 8'h00;
                    pass_n  = 1'b0;
                    valid_n = 1'b0;
                end
            end

            RUN: begin
                // First cycle of the stability window sets the reference;
                // any later window cycle that disagrees flags the row.
                if (cnt == WIN_START) begin
                    ref_bit_n = dut_out;
                end else if (cnt > WIN_START && dut_out != ref_bit) begin
                    unst_n[bit_idx] = 1'b1;
                end

                if (cnt == LAST_CNT) begin
                    tt_n[bit_idx] = dut_out;
                    cnt_n         = 8'd0;
                    if (row == 3'd7) begin
                        // Row returns to 0 so the drives read 000 while idle.
                        state_n = IDLE;
                        row_n   = 3'd0;
                        done_n  = 1'b1;
                        valid_n = 1'b1;
                        pass_n  = (tt_n == EXPECTED) && (unst_n == 8'h00);
                    end else begin
                        row_n = row + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign {drv_in2, drv_in1, drv_in3} = row;
    assign busy          = (state == RUN);
    assign done          = done_q;
    assign result_valid  = valid_q;
    assign tt            = tt_q;
    assign unstable_mask = unst_q;
    assign mismatch_mask = tt_q ^ EXPECTED;
    assign pass          = pass_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - bench for tt_sweep_capture (SETTLE=4/STABLE=2 and SETTLE=1/STABLE=1 instances)
module tb_tt_sweep_capture;

    localparam logic [7:0] EXP = 8'hBC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start_v, dut_out_v, busy_v, done_v, rv_v, pass_v, d2_v, d1_v, d3_v;
    logic [7:0] tt_v [2];
    logic [7:0] un_v [2];
    logic [7:0] mm_v [2];

    tt_sweep_capture #(.SETTLE(4), .STABLE(2), .EXPECTED(8'hBC)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .drv_in2(d2_v[0]), .drv_in1(d1_v[0]), .drv_in3(d3_v[0]),
        .dut_out(dut_out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .result_valid(rv_v[0]), .tt(tt_v[0]), .unstable_mask(un_v[0]),
        .mismatch_mask(mm_v[0]), .pass(pass_v[0])
    );

    tt_sweep_capture #(.SETTLE(1), .STABLE(1), .EXPECTED(8'hBC)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .drv_in2(d2_v[1]), .drv_in1(d1_v[1]), .drv_in3(d3_v[1]),
        .dut_out(dut_out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .result_valid(rv_v[1]), .tt(tt_v[1]), .unstable_mask(un_v[1]),
        .mismatch_mask(mm_v[1]), .pass(pass_v[1])
    );

    function automatic int s_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int st_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Behavioural circuit: truth-table code fn, optional random noise and a
    // single forced toggle at sweep cycle glitch_k.
    logic [7:0] fn [2];
    int         noise_pct [2];
    int         glitch_k [2];

    // Reference model: record every sampled output of a sweep, then derive the
    // results from the whole record when the sweep ends.
    bit         m_busy [2];
    bit         m_done [2];
    bit         m_valid [2];
    bit         m_pass [2];
    int         m_k [2];
    logic [7:0] m_tt [2];
    logic [7:0] m_un [2];
    bit         samp [2][64];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_sweep(int i);
        int s;
        int w;
        logic [7:0] t;
        logic [7:0] u;
        s = s_of(i);
        w = s - st_of(i);
        t = 8'h00;
        u = 8'h00;
        for (int r = 0; r < 8; r++) begin
            t[7 - r] = samp[i][r * s + s - 1];
            for (int j = w + 1; j < s; j++)
                if (samp[i][r * s + j] != samp[i][r * s + w]) u[7 - r] = 1'b1;
        end
        m_tt[i]    = t;
        m_un[i]    = u;
        m_valid[i] = 1;
        m_pass[i]  = (t == EXP) && (u == 8'h00);
        m_done[i]  = 1;
        m_busy[i]  = 0;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 0; m_done[i] = 0; m_valid[i] = 0; m_pass[i] = 0;
                m_k[i] = 0; m_tt[i] = 8'h00; m_un[i] = 8'h00;
            end else begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    samp[i][m_k[i]] = dut_out_v[i];
                    m_k[i]++;
                    if (m_k[i] == 8 * s_of(i)) finish_sweep(i);
                end else if (start_v[i]) begin
                    m_busy[i] = 1; m_k[i] = 0; m_tt[i] = 8'h00; m_un[i] = 8'h00;
                    m_valid[i] = 0; m_pass[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [2:0] row;
            logic       b;
            row = {d2_v[i], d1_v[i], d3_v[i]};
            b = fn[i][~row];
            if (noise_pct[i] > 0 && $urandom_range(0, 99) < noise_pct[i]) b = ~b;
            if (m_busy[i] && m_k[i] == glitch_k[i]) b = ~b;
            dut_out_v[i] = b;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d drv", i), {d2_v[i], d1_v[i], d3_v[i]},
                      m_busy[i] ? m_k[i] / s_of(i) : 0);
                check($sformatf("u%0d busy", i), busy_v[i], m_busy[i]);
                check($sformatf("u%0d done", i), done_v[i], m_done[i]);
                check($sformatf("u%0d result_valid", i), rv_v[i], m_valid[i]);
                check($sformatf("u%0d pass", i), pass_v[i], m_pass[i]);
                if (!m_busy[i]) begin
                    check($sformatf("u%0d tt", i), tt_v[i], m_tt[i]);
                    check($sformatf("u%0d unstable_mask", i), un_v[i], m_un[i]);
                    check($sformatf("u%0d mismatch_mask", i), mm_v[i], m_tt[i] ^ EXP);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_sweep(int i, bit jitter, output int lat);
        lat = -1;
        start_v[i] = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (done_v[i] === 1'b1) begin
                lat = c;
                start_v[i] = 1'b0;
                break;
            end
            start_v[i] = (jitter && m_busy[i]) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (lat < 0) begin
            start_v[i] = 1'b0;
            check($sformatf("u%0d sweep timeout", i), 0, 1);
        end
    endtask

    initial begin
        int lat;
        int nd;
        int times [3];
        rst = 1'b1;
        start_v = 2'b00;
        fn[0] = EXP; fn[1] = EXP;
        noise_pct[0] = 0; noise_pct[1] = 0;
        glitch_k[0] = -1; glitch_k[1] = -1;
        tick();
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;

        check("reset tt", tt_v[0], 8'h00);
        check("reset mismatch_mask", mm_v[0], 8'hBC);
        check("reset busy", busy_v[0], 1'b0);
        check("reset result_valid", rv_v[0], 1'b0);

        run_sweep(0, 0, lat);
        check("bc latency", lat, 32);
        check("bc tt", tt_v[0], 8'hBC);
        check("bc mismatch_mask", mm_v[0], 8'h00);
        check("bc unstable_mask", un_v[0], 8'h00);
        check("bc pass", pass_v[0], 1'b1);

        fn[0] = 8'hFF;
        run_sweep(0, 0, lat);
        check("ones tt", tt_v[0], 8'hFF);
        check("ones mismatch_mask", mm_v[0], 8'h43);
        check("ones pass", pass_v[0], 1'b0);
        fn[0] = 8'h00;
        run_sweep(0, 0, lat);
        check("zeros tt", tt_v[0], 8'h00);
        check("zeros mismatch_mask", mm_v[0], 8'hBC);

        fn[0] = EXP;
        glitch_k[0] = 15;
        run_sweep(0, 0, lat);
        check("glitch unstable_mask", un_v[0], 8'h10);
        check("glitch tt", tt_v[0], 8'hAC);
        check("glitch pass", pass_v[0], 1'b0);
        glitch_k[0] = -1;

        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 0; c < 100 && m_k[0] < 17; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort drives", {d2_v[0], d1_v[0], d3_v[0]}, 3'b000);
        check("abort busy", busy_v[0], 1'b0);
        check("abort tt", tt_v[0], 8'h00);
        check("abort result_valid", rv_v[0], 1'b0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_v[0] !== 1'b0) nd++;
        end
        check("abort no done", nd, 0);
        run_sweep(0, 0, lat);
        check("after abort tt", tt_v[0], 8'hBC);

        fn[1] = EXP;
        nd = 0;
        start_v[1] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (done_v[1] === 1'b1) begin
                times[nd] = c;
                nd++;
                if (nd == 3) begin
                    start_v[1] = 1'b0;
                    break;
                end
            end
        end
        start_v[1] = 1'b0;
        check("b2b done count", nd, 3);
        if (nd == 3) begin
            check("b2b first done", times[0], 8);
            check("b2b period 1", times[1] - times[0], 9);
            check("b2b period 2", times[2] - times[1], 9);
        end
        check("b2b tt", tt_v[1], 8'hBC);
        check("b2b pass", pass_v[1], 1'b1);

        noise_pct[1] = 30;
        run_sweep(1, 0, lat);
        check("settle1 unstable_mask", un_v[1], 8'h00);

        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 12; n++) begin
                fn[i] = 8'($urandom);
                noise_pct[i] = $urandom_range(0, 20);
                run_sweep(i, 1, lat);
                repeat ($urandom_range(0, 3)) tick();
            end
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
